overture_branch_sequencer: RTL and testbench

//  Fetch/issue sequencer for the OVERTURE core. Drives the program counter, fetches bytes from

---
 rtl/overture_branch_sequencer_if.sv | 30 +++
 rtl/overture_branch_sequencer.sv | 141 ++++++++++++++
 tb/tb_overture_branch_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/overture_branch_sequencer_if.sv
// Fetch/issue bundle for the OVERTURE branch sequencer.
// master: the sequencer. slave: instruction memory plus the register/ALU datapath.
interface overture_branch_sequencer_if;
    // Instruction memory handshake
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    // Datapath issue/feedback
    logic [7:0] instr;
    logic       instr_valid;
    logic       exec_done;
    logic [7:0] reg0;
    logic [7:0] reg3;
    logic       halt;
    // Status
    logic [7:0] pc;
    logic       branch_taken;
    logic       halted;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, branch_taken, halted,
        input  imem_ack, imem_data, exec_done, reg0, reg3, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, branch_taken, halted,
        output imem_ack, imem_data, exec_done, reg0, reg3, halt
    );
endinterface

// File: rtl/overture_branch_sequencer.sv
// OVERTURE fetch/issue sequencer: drives the PC, fetches instruction bytes over
// a req/ack handshake, issues them to the datapath and resolves condition-class
// instructions (class 2'b11) locally by testing reg3 and jumping to reg0.
// Optional feature: define BRANCH_STATS_EN to add the saturating taken_count port.
module overture_branch_sequencer #(
    parameter int         UUID     = 0,
    parameter string      NAME     = "",
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    overture_branch_sequencer_if.master  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [7:0]                   taken_count
`endif
);

    // UUID and NAME are informational; these empty blocks only tag the elaborated instance.
    if (UUID < 0) begin : g_uuid_negative
    end
    if (NAME == "") begin : g_unnamed
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALTED
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc_q;
    logic [7:0] pc_next;
    logic [7:0] instr_q;
    logic       branch_taken_q;
    logic       take;
    logic       is_cond;
    logic       op_zero;
    logic       op_neg;
    logic       cond_true;

    // Condition evaluation on reg3 as a signed byte: sign bit gives <0, all-zero gives ==0.
    always_comb begin
        op_zero   = (bus.reg3 == '0);
        op_neg    = bus.reg3[7];
        cond_true = 1'b0;
        case (instr_q[2:0])
            3'd0:    cond_true = 1'b0;
            3'd1:    cond_true = op_zero;
            3'd2:    cond_true = op_neg;
            3'd3:    cond_true = op_neg | op_zero;
            3'd4:    cond_true = 1'b1;
            3'd5:    cond_true = ~op_zero;
            3'd6:    cond_true = ~op_neg;
            default: cond_true = ~op_neg & ~op_zero;
        endcase
    end

    assign is_cond = (instr_q[7:6] == 2'b11);

    // Next-state, next-pc and jump decision.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        take       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = bus.halt ? S_HALTED : S_FETCH;
            end
            S_FETCH: begin
                // halt is deliberately not looked at: an outstanding fetch always completes
                if (bus.imem_ack) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_cond) begin
                    take       = cond_true;
                    pc_next    = cond_true ? bus.reg0 : pc_q + 8'd1;
                    state_next = bus.halt ? S_HALTED : S_FETCH;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.exec_done) begin
                    pc_next    = pc_q + 8'd1;
                    state_next = bus.halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                if (!bus.halt) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, PC, fetched instruction and branch pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc_q           <= PC_RESET;
            instr_q        <= '0;
            branch_taken_q <= 1'b0;
        end else begin
            state          <= state_next;
            pc_q           <= pc_next;
            branch_taken_q <= take;
            if ((state == S_FETCH) && bus.imem_ack) begin
                instr_q <= bus.imem_data;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating count of cycles with branch_taken high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            taken_count <= '0;
        end else if (branch_taken_q && (taken_count != '1)) begin
            taken_count <= taken_count + 8'd1;
        end
    end
`endif

    assign bus.imem_req     = (state == S_FETCH);
    assign bus.imem_addr    = pc_q;
    assign bus.instr        = instr_q;
    assign bus.instr_valid  = (state == S_ISSUE);
    assign bus.pc           = pc_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.halted       = (state == S_HALTED);

endmodule

// File: tb/tb_overture_branch_sequencer.sv
// Self-checking bench for overture_branch_sequencer (PC_RESET = 0x10).
// Expected instructions and branch outcomes are queued when a fetch is acked
// and compared by a monitor when the DUT issues.
module tb_overture_branch_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    overture_branch_sequencer_if bus ();

`ifdef BRANCH_STATS_EN
    logic [7:0] taken_count;
`endif

    overture_branch_sequencer #(
        .UUID     (1),
        .NAME     ("tb_seq"),
        .PC_RESET (8'h10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count (taken_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_instr_q[$];
    logic [8:0] exp_br_q[$];
    logic [7:0] model_pc;
    bit         br_pend = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_model(input logic [2:0] c, input logic [7:0] r);
        logic signed [7:0] s;
        s = r;
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return s == 0;
            3'd2:    return s < 0;
            3'd3:    return s <= 0;
            3'd4:    return 1'b1;
            3'd5:    return s != 0;
            3'd6:    return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // Monitor: compare issued instructions and the branch outcome one cycle later.
    initial begin
        logic [8:0] e;
        logic [7:0] ei;
        forever begin
            @(negedge clk);
            if (br_pend) begin
                br_pend = 1'b0;
                check_eq("br_q_avail", exp_br_q.size() != 0, 1);
                if (exp_br_q.size() != 0) begin
                    e = exp_br_q.pop_front();
                    check_eq("branch_taken", bus.branch_taken, e[8]);
                    check_eq("branch_pc", bus.pc, e[7:0]);
                end
            end else if (rst) begin
                check_eq("no_spurious_bt", bus.branch_taken, 0);
            end
            if (rst && bus.instr_valid) begin
                check_eq("instr_q_avail", exp_instr_q.size() != 0, 1);
                if (exp_instr_q.size() != 0) begin
                    ei = exp_instr_q.pop_front();
                    check_eq("issued_instr", bus.instr, ei);
                end
                if (bus.instr[7:6] == 2'b11) br_pend = 1'b1;
            end
        end
    end

    // One full fetch/issue/complete of a single instruction, starting at a negedge.
    task automatic run_instr(input logic [7:0] data, input int unsigned ack_delay, input bit halt_mid);
        int unsigned n;
        logic        taken;
        logic [7:0]  nxt;
        n = 0;
        while (!bus.imem_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_seen", bus.imem_req, 1);
        check_eq("fetch_addr", bus.imem_addr, model_pc);
        for (int unsigned i = 0; i < ack_delay; i++) begin
            if (halt_mid && i == 0) bus.halt = 1'b1;
            @(negedge clk);
            check_eq("req_held", bus.imem_req, 1);
            check_eq("addr_stable", bus.imem_addr, model_pc);
        end
        taken = 1'b0;
        nxt   = model_pc + 8'd1;
        exp_instr_q.push_back(data);
        if (data[7:6] == 2'b11) begin
            taken = cond_model(data[2:0], bus.reg3);
            nxt   = taken ? bus.reg0 : model_pc + 8'd1;
            exp_br_q.push_back({taken, nxt});
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = data;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'hA5;
        check_eq("issue_pulse", bus.instr_valid, 1);
        @(negedge clk);
        check_eq("valid_one_cycle", bus.instr_valid, 0);
        if (data[7:6] == 2'b11) begin
            model_pc = nxt;
        end else begin
            check_eq("wait_pc_hold", bus.pc, model_pc);
            @(negedge clk);
            check_eq("wait_pc_hold2", bus.pc, model_pc);
            bus.exec_done = 1'b1;
            @(negedge clk);
            bus.exec_done = 1'b0;
            model_pc = model_pc + 8'd1;
            check_eq("exec_pc", bus.pc, model_pc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"}, bus.pc, 8'h10);
        check_eq({tag, "_req"}, bus.imem_req, 0);
        check_eq({tag, "_valid"}, bus.instr_valid, 0);
        check_eq({tag, "_bt"}, bus.branch_taken, 0);
        check_eq({tag, "_halted"}, bus.halted, 0);
        check_eq({tag, "_instr"}, bus.instr, 0);
`ifdef BRANCH_STATS_EN
        check_eq({tag, "_taken_count"}, taken_count, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r3_vals[4];
        int unsigned n;
        r3_vals = '{8'h00, 8'h01, 8'h80, 8'h7F};

        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        bus.exec_done = 1'b0;
        bus.reg0      = 8'h00;
        bus.reg3      = 8'h00;
        bus.halt      = 1'b0;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Release reset: IDLE one cycle, then FETCH at PC_RESET.
        rst      = 1'b1;
        model_pc = 8'h10;
        @(negedge clk);
        check_eq("req_after_reset", bus.imem_req, 1);
        check_eq("addr_after_reset", bus.imem_addr, 8'h10);

        // Slow fetch of a non-condition instruction.
        run_instr(8'h00, 3, 1'b0);
        check_eq("pc_after_first", bus.pc, 8'h11);

        // Condition sweep.
        bus.reg0 = 8'h40;
        for (int unsigned c = 0; c < 8; c++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                bus.reg3 = r3_vals[k];
                run_instr(8'hC0 | 8'(c), 0, 1'b0);
            end
        end

        // PC wrap and tight loop at 0xFF.
        bus.reg0 = 8'hFF;
        run_instr(8'hC4, 0, 1'b0);
        run_instr(8'h01, 1, 1'b0);
        check_eq("pc_wrap", bus.pc, 8'h00);
        run_instr(8'hC4, 0, 1'b0);
        run_instr(8'hC4, 0, 1'b0);
        check_eq("tight_loop_pc", bus.pc, 8'hFF);

        // Halt raised mid-fetch: fetch completes and issues, then halted.
        bus.reg3 = 8'h01;
        run_instr(8'hC0, 2, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            check_eq("halted_flag", bus.halted, 1);
            check_eq("halted_no_req", bus.imem_req, 0);
            check_eq("halted_pc", bus.pc, model_pc);
            @(negedge clk);
        end
        bus.halt = 1'b0;
        run_instr(8'h3A, 0, 1'b0);
        check_eq("halted_released", bus.halted, 0);

        // Reset while in WAIT with imem_ack raised.
        n = 0;
        while (!bus.imem_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        exp_instr_q.push_back(8'h05);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h05;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check_eq("wait_issue", bus.instr_valid, 1);
        @(negedge clk);
        rst          = 1'b0;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        check_reset_values("reset_in_wait");
        rst = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check_eq("late_ack_instr", bus.instr, 0);
        check_eq("late_ack_valid", bus.instr_valid, 0);
        model_pc = 8'h10;

`ifdef BRANCH_STATS_EN
        bus.reg0 = 8'h10;
        for (int unsigned i = 0; i < 3; i++) run_instr(8'hC4, 0, 1'b0);
        @(negedge clk);
        check_eq("taken_count_3", taken_count, 3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("taken_count_cleared", taken_count, 0);
        rst      = 1'b1;
        model_pc = 8'h10;
        @(negedge clk);
`endif

        check_eq("instr_q_drained", exp_instr_q.size(), 0);
        check_eq("br_q_drained", exp_br_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
